rgb_fader: RTL and testbench
============================

# rgb_fader

Parametrised N-channel PWM LED controller with glitch-free duty updates and hardware linear fading. It sits between the control/register logic and the on-chip LED current driver (SB_RGBA_DRV in the top level). It takes per-channel target intensities and ramps each channel's duty toward its target at a programmable rate, one step per PWM period. Raw PWM outputs only; driver instantiation stays in the top level.

## Interface
- NCH, 3, number of channels (R,G,B = channels 2,1,0 by convention)
- NBPC, 8, bits per channel; PWM period MAX = 2^NBPC-1 counter ticks
- PRESC_W, 16, prescaler width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low freezes PWM and forces outputs off
- presc  in  PRESC_W  PWM tick divider; counter advances every presc+1 clk cycles
- fade_step  in  NBPC  duty change per PWM period; 0 = jump to target
- load  in  1  single-cycle strobe: capture target into shadow registers
- target  in  NCH*NBPC  channel i at [(i+1)*NBPC-1 : i*NBPC]
- pwm  out  NCH  registered PWM outputs
- busy  out  1  high while any duty differs from its shadow target
- period_tick  out  1  one-cycle pulse at each PWM period boundary

## Operation
- Prescaler: counts 0..presc; tick when it equals presc, then returns to 0. presc changes take effect on next wrap; if count > new presc, it wraps next cycle.
- PWM counter: advances on tick, 0..MAX-1, wraps to 0. Boundary = tick while counter == MAX-1.
- Compare: pwm[i] <= (count < duty[i]); duty 0 = always off, duty MAX = always on.
- Shadow: on load, shadow[i] <= target slice. Accepted regardless of en. Repeated loads: last wins.
- Duty update, only at boundary, per channel, using shadow as it was before that cycle (a load coinciding with the boundary applies at the next boundary):
  - fade_step == 0 or |shadow-duty| <= fade_step: duty <= shadow
  - shadow > duty: duty <= duty + fade_step; else duty <= duty - fade_step
  - difference computed NBPC+1 bits wide; no wrap, no overshoot.
- busy = OR over channels (duty != shadow), combinational from registers.
- en low: prescaler and counter held at 0, pwm forced 0 next cycle, duty and shadow held, no period_tick. en rising: counting resumes from 0.

## Timing
- Reset values: pwm = 0, period_tick = 0, busy = 0, duty = 0, shadow = 0, counter = 0, prescaler = 0.
- Reset mid-fade: all state returns to reset values immediately (async); no pending load survives.
- pwm latency: one clk after counter/duty change.
- load -> shadow: visible next cycle; busy rises the cycle after load if target differs from duty.
- Duty changes only on the cycle after a boundary, so each period's pulse width is consistent (no glitch).
- period_tick: registered, high for exactly one clk, the cycle after boundary (aligned with counter == 0 and updated duty).
- Full fade from 0 to MAX with step s takes ceil(MAX/s) periods; PWM period = MAX*(presc+1) clk.

## Structure
- Shared package/header: channel-slice macro, MAX derivation from NBPC; no enums needed.
- One sub-module natural: rgb_fader_chan (shadow, duty, fade arithmetic, compare) instantiated NCH times via generate; prescaler, counter, period_tick, busy reduction in the top.
- Reuse the existing counter module for the PWM counter (min 0, max MAX-1, step 1, en = tick & en).

## Test plan
- Reset/idle: rst_n low mid-run -> pwm=0, busy=0, period_tick=0 immediately; after release with no load, pwm stays 0.
- Immediate load: NBPC=8, presc=0, fade_step=0, load target R=0x80 G=0xFF B=0x00 -> after first boundary R high 128/255 cycles, G constantly high, B constantly low; busy drops after that boundary.
- Fade up/down: fade_step=0x10, load R=0xFF from 0 -> duty 0x10,0x20..0xF0 then 0xFF in 16 periods; reload 0x05 -> 0xEF..0x0F then 0x05; no overshoot.
- Boundary collision: load on the exact boundary cycle -> duty unchanged at that boundary, applied at next; load twice in one period -> only second value reached.
- Prescaler: presc=3 -> period_tick every 255*4 = 1020 clk; presc change mid-period takes effect at next prescaler wrap.
- Enable: drop en mid-fade -> pwm 0 next cycle, duty frozen, no period_tick; raise en -> counter restarts at 0, fade continues from frozen duty.

Source files
------------

// File: rtl/rgb_fader_pkg.sv
// Shared helpers for the rgb_fader block: PWM period derivation and
// channel slice positions inside the packed target bus.
package rgb_fader_pkg;

    // Number of counter ticks in one PWM period for a given duty width.
    // A duty of pwm_max() keeps the output high for the whole period.
    function automatic int pwm_max(input int nbpc);
        return (1 << nbpc) - 1;
    endfunction

    // Low bit of channel ch inside a packed NCH*NBPC bus.
    // Use as bus[chan_lo(ch, NBPC) +: NBPC].
    function automatic int chan_lo(input int ch, input int nbpc);
        return ch * nbpc;
    endfunction

endpackage

// File: rtl/rgb_fader_chan.sv
// One PWM channel: shadow target, current duty, linear fade step
// applied at each period boundary, and the registered compare output.
module rgb_fader_chan
    import rgb_fader_pkg::*;
#(
    parameter int NBPC = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            load,
    input  logic [NBPC-1:0] target,
    input  logic [NBPC-1:0] fade_step,
    input  logic            boundary,
    input  logic [NBPC-1:0] count,
    output logic            pwm,
    output logic            busy
);

    logic [NBPC-1:0] shadow;
    logic [NBPC-1:0] duty;
    logic [NBPC-1:0] duty_next;
    logic [NBPC:0]   diff;
    logic            up;

    // Next duty value: jump when the step is zero or would reach/overshoot
    // the shadow, otherwise move one step toward it. The distance is
    // computed one bit wider so it never wraps.
    always_comb begin
        up        = (shadow > duty);
        diff      = up ? ({1'b0, shadow} - {1'b0, duty})
                       : ({1'b0, duty} - {1'b0, shadow});
        duty_next = duty;
        if ((fade_step == '0) || (diff <= {1'b0, fade_step})) begin
            duty_next = shadow;
        end else if (up) begin
            duty_next = duty + fade_step;
        end else begin
            duty_next = duty - fade_step;
        end
    end

    // Shadow capture: every load strobe overwrites it, even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= target;
        end
    end

    // Duty update only at a period boundary, so a period never changes
    // pulse width half way through. A load in the same cycle is not seen
    // here because shadow is still the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= '0;
        end else if (boundary) begin
            duty <= duty_next;
        end
    end

    // Registered compare; forced low while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= en && (count < duty);
        end
    end

    assign busy = (duty != shadow);

endmodule

// File: rtl/rgb_fader_counter.sv
// Generic up-counter with synchronous clear: counts MIN..MAX in STEP
// increments while en is high and wraps back to MIN after MAX.
module rgb_fader_counter
    import rgb_fader_pkg::*;
#(
    parameter int W    = 8,
    parameter int MIN  = 0,
    parameter int MAX  = 254,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MIN_V  = W'(MIN);
    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] STEP_V = W'(STEP);

    // Count register: clear wins over enable; wrap once the next step
    // would pass MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= MIN_V;
        end else if (clr) begin
            value <= MIN_V;
        end else if (en) begin
            if (value > MAX_V - STEP_V) begin
                value <= MIN_V;
            end else begin
                value <= value + STEP_V;
            end
        end
    end

endmodule

// File: rtl/rgb_fader.sv
// N-channel PWM LED fader: shared prescaler and period counter, one
// rgb_fader_chan per channel, and the period/busy status outputs.
//
// load is a single-cycle strobe with no back-pressure: every cycle in
// which load is high captures target into the shadows; the last capture
// before a period boundary is the one the duties move toward.
module rgb_fader
    import rgb_fader_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int NBPC    = 8,
    parameter int PRESC_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PRESC_W-1:0]  presc,
    input  logic [NBPC-1:0]     fade_step,
    input  logic                load,
    input  logic [NCH*NBPC-1:0] target,
    output logic [NCH-1:0]      pwm,
    output logic                busy,
    output logic                period_tick
);

    localparam int              MAX  = pwm_max(NBPC);
    localparam logic [NBPC-1:0] LAST = NBPC'(MAX - 1);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic               cnt_en;
    logic               cnt_clr;
    logic               boundary;
    logic [NBPC-1:0]    count;
    logic [NCH-1:0]     chan_busy;

    assign tick     = en && (presc_cnt == presc);
    assign cnt_en   = tick && en;
    assign cnt_clr  = !en;
    assign boundary = tick && (count == LAST);

    // Prescaler: wraps on reaching presc, or immediately if presc was
    // lowered below the current count; held at 0 while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (!en) begin
            presc_cnt <= '0;
        end else if (presc_cnt >= presc) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    rgb_fader_counter #(
        .W    (NBPC),
        .MIN  (0),
        .MAX  (MAX - 1),
        .STEP (1)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .value (count)
    );

    // Period pulse: lines up with counter == 0 and the freshly updated duties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_tick <= 1'b0;
        end else begin
            period_tick <= boundary;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        rgb_fader_chan #(
            .NBPC (NBPC)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .load      (load),
            .target    (target[chan_lo(i, NBPC) +: NBPC]),
            .fade_step (fade_step),
            .boundary  (boundary),
            .count     (count),
            .pwm       (pwm[i]),
            .busy      (chan_busy[i])
        );
    end

    assign busy = |chan_busy;

endmodule

// File: tb/tb_rgb_fader.sv
// Directed bench for rgb_fader: duty is observed as the number of pwm-high
// clocks between consecutive period_tick pulses.
module tb_rgb_fader;

    localparam int BUDGET = 5000;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] presc;
    logic [7:0]  fade_step;
    logic        load;
    logic [23:0] target;
    logic [2:0]  pwm;
    logic        busy;
    logic        period_tick;

    int n_pass;
    int n_total;
    int m_hi[3];
    int m_clks;
    int m_busy;

    typedef struct {
        logic [23:0] target;
        int          exp_r;
        int          exp_g;
        int          exp_b;
    } vec_t;

    vec_t vecs[4];

    rgb_fader #(
        .NCH     (3),
        .NBPC    (8),
        .PRESC_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .presc       (presc),
        .fade_step   (fade_step),
        .load        (load),
        .target      (target),
        .pwm         (pwm),
        .busy        (busy),
        .period_tick (period_tick)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic do_load(input logic [23:0] t);
        load   = 1'b1;
        target = t;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!period_tick && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!period_tick) check("tick_timeout", 0, 1);
    endtask

    // Samples from the next clock up to and including the next period_tick.
    task automatic sample_until_tick(input int change_at, input logic [15:0] new_presc);
        for (int i = 0; i < 3; i++) m_hi[i] = 0;
        m_clks = 0;
        do begin
            @(negedge clk);
            m_clks++;
            for (int i = 0; i < 3; i++) m_hi[i] += int'(pwm[i]);
            if (m_clks == change_at) presc = new_presc;
        end while (!period_tick && m_clks < BUDGET);
        if (!period_tick) check("period_timeout", 0, 1);
    endtask

    task automatic measure();
        wait_tick();
        m_busy = int'(busy);
        sample_until_tick(-1, presc);
    endtask

    task automatic check_period(input string tag, input int r, input int g,
                                input int b, input int clks);
        check($sformatf("%s_r", tag), m_hi[2], r);
        check($sformatf("%s_g", tag), m_hi[1], g);
        check($sformatf("%s_b", tag), m_hi[0], b);
        check($sformatf("%s_clks", tag), m_clks, clks);
    endtask

    initial begin
        int viol;
        int ticks;

        n_pass = 0;
        n_total = 0;
        vecs[0] = '{24'h80FF00, 128, 255, 0};
        vecs[1] = '{24'h0001FE, 0, 1, 254};
        vecs[2] = '{24'hFF007F, 255, 0, 127};
        vecs[3] = '{24'h000000, 0, 0, 0};

        rst_n = 1'b0;
        en = 1'b1;
        presc = 16'd0;
        fade_step = 8'd0;
        load = 1'b0;
        target = 24'd0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(period_tick), 0);
        rst_n = 1'b1;

        measure();
        check_period("idle", 0, 0, 0, 255);
        check("idle_busy", m_busy, 0);

        // table: immediate loads with fade_step 0
        for (int v = 0; v < 4; v++) begin
            do_load(vecs[v].target);
            if (vecs[v].target != 24'h000000 || v == 0)
                check($sformatf("vec%0d_busy_rise", v), int'(busy), 1);
            measure();
            check($sformatf("vec%0d_busy_drop", v), m_busy, 0);
            check_period($sformatf("vec%0d", v), vecs[v].exp_r, vecs[v].exp_g,
                         vecs[v].exp_b, 255);
        end

        // fade up 0 -> FF in steps of 0x10
        fade_step = 8'h10;
        do_load(24'hFF0000);
        for (int k = 1; k <= 16; k++) begin
            measure();
            check($sformatf("up%0d_r", k), m_hi[2], (k < 16) ? 16 * k : 255);
            check($sformatf("up%0d_busy", k), m_busy, (k < 16) ? 1 : 0);
        end
        check("up_g", m_hi[1], 0);

        // fade down FF -> 05
        do_load(24'h050000);
        for (int k = 1; k <= 16; k++) begin
            measure();
            check($sformatf("dn%0d_r", k), m_hi[2], (k < 16) ? 255 - 16 * k : 5);
        end

        // load exactly on the boundary cycle: applied one period later
        fade_step = 8'h00;
        repeat (254) @(negedge clk);
        do_load(24'h402010);
        check("coll_tick", int'(period_tick), 1);
        check("coll_busy", int'(busy), 1);
        measure();
        check_period("coll_old", 5, 0, 0, 255);
        measure();
        check_period("coll_new", 64, 32, 16, 255);

        // two loads in one period: only the second is reached
        do_load(24'hAAAAAA);
        repeat (50) @(negedge clk);
        do_load(24'hFF3300);
        measure();
        check_period("dbl", 255, 51, 0, 255);

        // prescaler 3: 1020 clk per period, 4 clk per count
        presc = 16'd3;
        measure();
        check_period("presc3", 1020, 204, 0, 1020);

        // presc 3 -> 1 100 clocks into the period (prescaler is at 0 then)
        wait_tick();
        sample_until_tick(100, 16'd1);
        check_period("presc_chg", 560, 152, 0, 560);

        presc = 16'd0;
        measure();
        check("presc0_clks", m_clks, 255);

        // enable drop mid-fade
        fade_step = 8'h10;
        do_load(24'h000080);
        measure();
        check_period("en_f1", 239, 35, 16, 255);
        repeat (100) @(negedge clk);
        check("pre_en_pwm_r", int'(pwm[2]), 1);
        en = 1'b0;
        viol = 0;
        ticks = 0;
        repeat (600) begin
            @(negedge clk);
            if (pwm != 3'b000) viol++;
            if (period_tick) ticks++;
        end
        check("en_low_pwm", viol, 0);
        check("en_low_ticks", ticks, 0);
        check("en_low_busy", int'(busy), 1);
        en = 1'b1;
        sample_until_tick(-1, presc);
        check_period("en_resume", 223, 19, 32, 255);
        measure();
        check_period("en_f3", 207, 3, 48, 255);

        // asynchronous reset mid-fade
        repeat (100) @(negedge clk);
        check("pre_rst_pwm_r", int'(pwm[2]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm", int'(pwm), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_tick", int'(period_tick), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        measure();
        check_period("post_rst", 0, 0, 0, 255);
        check("post_rst_busy", m_busy, 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
